// File: rtl/msx_bus_pkg.sv
// Shared types and constants for the MSX cartridge bus slave front end.
package msx_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RD_HOLD,
        ST_WAIT_END
    } msx_state_e;

    localparam logic [7:0] MSX_BUS_IDLE_DATA = 8'hFF;
    localparam int         WAIT_CNT_W        = 16;

endpackage

// File: rtl/msx_bus_sync.sv
// Multi-flop synchroniser for one asynchronous active-low MSX strobe.
// Resets to 1 so that a reset never looks like an asserted strobe.
module msx_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/msx_bus_slave.sv
// MSX cartridge bus slave: turns synchronised slot strobes into one valid/ready request.
// Optional read-wait timeout enabled by defining MSX_BUS_SLAVE_TIMEOUT_EN.
module msx_bus_slave
    import msx_bus_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n_ce,
    input  logic              n_twr,
    input  logic              n_trd,
    input  logic [ADDR_W-1:0] ta,
    input  logic [7:0]        td_in,
    output logic [7:0]        td_out,
    output logic              tdir,
    output logic              twait,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_address,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_rdata_en,
    output logic              timeout_pulse
);

    logic [2:0] strb_raw;
    logic [2:0] strb_s;
    logic       s_ce, s_twr, s_trd;

    assign strb_raw = {n_ce, n_twr, n_trd};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        msx_bus_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (clk),
            .reset (reset),
            .d     (strb_raw[i]),
            .q     (strb_s[i])
        );
    end

    assign s_ce  = strb_s[2];
    assign s_twr = strb_s[1];
    assign s_trd = strb_s[0];

    msx_state_e        state_q, state_d;
    logic [7:0]        td_out_q, td_out_d;
    logic              tdir_q, tdir_d;
    logic              twait_q, twait_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_write_q, bus_write_d;
    logic [ADDR_W-1:0] bus_address_q, bus_address_d;
    logic [7:0]        bus_wdata_q, bus_wdata_d;
    logic              timeout_pulse_q, timeout_pulse_d;
    logic              enter_rd, timeout_hit, rd_release;
    logic              do_data, do_timeout, do_abort;

`ifdef MSX_BUS_SLAVE_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Fires on the cycle whose increment makes the count reach WAIT_TIMEOUT.
    assign timeout_hit = twait_q && (wait_cnt_q == WAIT_CNT_W'(WAIT_TIMEOUT - 1));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (enter_rd) begin
            wait_cnt_d = '0;
        end else if (twait_q) begin
            wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^{WAIT_TIMEOUT, enter_rd};
`endif

    // The host releasing either strobe ends any read in flight.
    assign rd_release = s_trd | s_ce;

    always_comb begin
        state_d         = state_q;
        td_out_d        = td_out_q;
        tdir_d          = tdir_q;
        twait_d         = twait_q;
        bus_valid_d     = bus_valid_q;
        bus_write_d     = bus_write_q;
        bus_address_d   = bus_address_q;
        bus_wdata_d     = bus_wdata_q;
        timeout_pulse_d = 1'b0;
        enter_rd        = 1'b0;
        do_data         = 1'b0;
        do_timeout      = 1'b0;
        do_abort        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!s_ce) begin
                    if (!s_twr && s_trd) begin
                        bus_valid_d   = 1'b1;
                        bus_write_d   = 1'b1;
                        bus_address_d = ta;
                        bus_wdata_d   = td_in;
                        state_d       = ST_WR_REQ;
                    end else if (s_twr && !s_trd) begin
                        bus_valid_d   = 1'b1;
                        bus_write_d   = 1'b0;
                        bus_address_d = ta;
                        twait_d       = 1'b1;
                        enter_rd      = 1'b1;
                        state_d       = ST_RD_REQ;
                    end else if (!s_twr && !s_trd) begin
                        state_d = ST_WAIT_END;
                    end
                end
            end
            ST_WR_REQ: begin
                if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = ST_WAIT_END;
                end
            end
            ST_RD_REQ: begin
                if (rd_release) begin
                    do_abort = 1'b1;
                end else if (bus_ready && bus_rdata_en) begin
                    do_data = 1'b1;
                end else if (timeout_hit) begin
                    do_timeout = 1'b1;
                end else if (bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rd_release) begin
                    do_abort = 1'b1;
                end else if (bus_rdata_en) begin
                    do_data = 1'b1;
                end else if (timeout_hit) begin
                    do_timeout = 1'b1;
                end
            end
            ST_RD_HOLD: begin
                if (rd_release) begin
                    tdir_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_END: begin
                if (s_ce || (s_twr && s_trd)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_abort) begin
            bus_valid_d = 1'b0;
            twait_d     = 1'b0;
            tdir_d      = 1'b0;
            state_d     = ST_IDLE;
        end
        if (do_data) begin
            bus_valid_d = 1'b0;
            td_out_d    = bus_rdata;
            tdir_d      = 1'b1;
            twait_d     = 1'b0;
            state_d     = ST_RD_HOLD;
        end
        if (do_timeout) begin
            bus_valid_d     = 1'b0;
            td_out_d        = MSX_BUS_IDLE_DATA;
            tdir_d          = 1'b1;
            twait_d         = 1'b0;
            timeout_pulse_d = 1'b1;
            state_d         = ST_RD_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            td_out_q        <= MSX_BUS_IDLE_DATA;
            tdir_q          <= 1'b0;
            twait_q         <= 1'b0;
            bus_valid_q     <= 1'b0;
            bus_write_q     <= 1'b0;
            bus_address_q   <= '0;
            bus_wdata_q     <= '0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            td_out_q        <= td_out_d;
            tdir_q          <= tdir_d;
            twait_q         <= twait_d;
            bus_valid_q     <= bus_valid_d;
            bus_write_q     <= bus_write_d;
            bus_address_q   <= bus_address_d;
            bus_wdata_q     <= bus_wdata_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    assign td_out        = td_out_q;
    assign tdir          = tdir_q;
    assign twait         = twait_q;
    assign bus_valid     = bus_valid_q;
    assign bus_write     = bus_write_q;
    assign bus_address   = bus_address_q;
    assign bus_wdata     = bus_wdata_q;
    assign timeout_pulse = timeout_pulse_q;

endmodule
